// File: rtl/cmd_encoder_if.sv
// Command-in / byte-out handshake bundle for cmd_encoder.
// The master issues commands and sinks bytes; the encoder is the slave.
interface cmd_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_id;
    logic [3:0]  cmd_index;
    logic [63:0] cmd_value;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_id, cmd_index, cmd_value, tx_ready,
        input  cmd_ready, tx_data, tx_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_id, cmd_index, cmd_value, tx_ready,
        output cmd_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/cmd_encoder.sv
// Serialises one structured command into the ASCII frame the server
// command parser consumes: b/f/t/h frames, newline terminated.
module cmd_encoder #(
    parameter int BIN_W = 8,
    parameter int DEC_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cmd_encoder_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int NDIG  = 6;
    localparam int BCD_W = 4 * NDIG;
    localparam int CCW   = $clog2(DEC_W) + 1;
    localparam int SUBW  = $clog2(BIN_W + NDIG) + 1;

    localparam logic [1:0] OP_B = 2'd0;
    localparam logic [1:0] OP_F = 2'd1;
    localparam logic [1:0] OP_T = 2'd2;
    localparam logic [1:0] OP_H = 2'd3;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_NL = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_SEND
    } state_t;

    typedef enum logic [2:0] {
        G_OP,
        G_SP1,
        G_ID,
        G_SP2,
        G_IDX,
        G_SP3,
        G_VAL,
        G_NL
    } seg_t;

    state_t           state_q;
    state_t           state_n;
    seg_t             seg_q;
    seg_t             seg_n;
    seg_t             seg_nxt;
    logic [SUBW-1:0]  sub_q;
    logic [SUBW-1:0]  sub_n;
    logic             init_q;
    logic [1:0]       op_q;
    logic [1:0]       id_q;
    logic [3:0]       idx_q;
    logic [BIN_W-1:0] bval_q;
    logic [DEC_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [CCW-1:0]   ccnt_q;
    logic             accept;
    logic             done;
    logic             seg_last;
    logic [7:0]       ch;
    logic [SUBW-1:0]  ndig;
    logic [SUBW-1:0]  dsh;
    logic [BIN_W-1:0] bval_sh;
    logic [BCD_W-1:0] bcd_sh;
    logic             unused_bits;

    assign unused_bits = ^{bus.cmd_value, bcd_adj[BCD_W-1],
                           bval_sh[BIN_W-2:0], bcd_sh[BCD_W-5:0]};

    assign busy = (state_q != S_IDLE);

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd_adj[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
            end
        end
    end

    // Significant decimal digits; a zero value still shows one digit
    always_comb begin
        ndig = SUBW'(1);
        for (int k = 1; k < NDIG; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                ndig = SUBW'(k + 1);
            end
        end
        dsh     = SUBW'(NDIG) - ndig + sub_q;
        bcd_sh  = bcd_q << {dsh, 2'b00};
        bval_sh = bval_q << sub_q;
    end

    always_comb begin
        ch       = 8'h00;
        seg_last = 1'b1;
        seg_nxt  = G_NL;
        unique case (seg_q)
            G_OP: begin
                unique case (op_q)
                    OP_B: ch = 8'h62;
                    OP_F: ch = 8'h66;
                    OP_T: ch = 8'h74;
                    OP_H: ch = 8'h68;
                endcase
                seg_nxt = (op_q == OP_B || op_q == OP_F) ? G_SP1 : G_NL;
            end
            G_SP1: begin
                ch      = CH_SP;
                seg_nxt = G_ID;
            end
            G_ID: begin
                ch       = CH_0 | {7'd0, (sub_q[0] ? id_q[0] : id_q[1])};
                seg_last = sub_q[0];
                seg_nxt  = G_SP2;
            end
            G_SP2: begin
                ch      = CH_SP;
                seg_nxt = G_IDX;
            end
            G_IDX: begin
                if (idx_q >= 4'd10) begin
                    ch = sub_q[0] ? (CH_0 + {4'd0, idx_q - 4'd10}) : 8'h31;
                    seg_last = sub_q[0];
                end else begin
                    ch = CH_0 + {4'd0, idx_q};
                end
                seg_nxt = G_SP3;
            end
            G_SP3: begin
                ch      = CH_SP;
                seg_nxt = G_VAL;
            end
            G_VAL: begin
                if (op_q == OP_B) begin
                    ch       = CH_0 | {7'd0, bval_sh[BIN_W-1]};
                    seg_last = (sub_q == SUBW'(BIN_W - 1));
                end else begin
                    ch       = CH_0 | {4'd0, bcd_sh[BCD_W-1 -: 4]};
                    seg_last = (sub_q == ndig - SUBW'(1));
                end
                seg_nxt = G_NL;
            end
            G_NL: begin
                ch = CH_NL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        seg_n         = seg_q;
        sub_n         = sub_q;
        accept        = 1'b0;
        done          = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                bus.cmd_ready = init_q;
                if (bus.cmd_valid && init_q) begin
                    accept  = 1'b1;
                    seg_n   = G_OP;
                    sub_n   = '0;
                    state_n = (bus.cmd_op == OP_F) ? S_CONV : S_SEND;
                end
            end
            S_CONV: begin
                if (ccnt_q == CCW'(DEC_W - 1)) begin
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = ch;
                if (bus.tx_ready) begin
                    if (!seg_last) begin
                        sub_n = sub_q + SUBW'(1);
                    end else if (seg_q == G_NL) begin
                        done    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        seg_n = seg_nxt;
                        sub_n = '0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q    <= 1'b0;
            seg_q     <= G_OP;
            sub_q     <= '0;
            op_q      <= '0;
            id_q      <= '0;
            idx_q     <= '0;
            bval_q    <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            ccnt_q    <= '0;
            frame_cnt <= '0;
        end else begin
            init_q <= 1'b1;
            seg_q  <= seg_n;
            sub_q  <= sub_n;
            if (accept) begin
                op_q   <= bus.cmd_op;
                id_q   <= bus.cmd_id;
                idx_q  <= bus.cmd_index;
                bval_q <= bus.cmd_value[BIN_W-1:0];
                bin_q  <= bus.cmd_value[DEC_W-1:0];
                bcd_q  <= '0;
                ccnt_q <= '0;
            end else if (state_q == S_CONV) begin
                bin_q  <= bin_q << 1;
                bcd_q  <= {bcd_adj[BCD_W-2:0], bin_q[DEC_W-1]};
                ccnt_q <= ccnt_q + CCW'(1);
            end
            if (done) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cmd_encoder.sv
// Self-checking bench for cmd_encoder
// against a string model of the frames.
module tb_cmd_encoder;
  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        busy2;
  logic [1:0]  fc2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  cmd_encoder_if bus ();
  cmd_encoder_if bus2 ();

  cmd_encoder #(.BIN_W(8), .DEC_W(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  cmd_encoder #(.BIN_W(8), .DEC_W(16), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .busy      (busy2),
    .frame_cnt (fc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string model(
    input logic [1:0] op, input logic [1:0] id,
    input logic [3:0] idx, input logic [63:0] v);
    case (op)
      2'd0: return $sformatf("b %0d%0d %0d %08b\n",
                             id[1], id[0], idx, v[7:0]);
      2'd1: return $sformatf("f %0d%0d %0d %0d\n",
                             id[1], id[0], idx, v[15:0]);
      2'd2: return "t\n";
      default: return "h\n";
    endcase
  endfunction

  function automatic string vis(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) r = {r, "<NL>"};
      else r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  task automatic send_cmd(
    input logic [1:0] op, input logic [1:0] id,
    input logic [3:0] idx, input logic [63:0] v,
    input bit hold, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_id    = id;
    bus.cmd_index = idx;
    bus.cmd_value = v;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.cmd_op    = hold ? 2'd2 : 2'($urandom);
    bus.cmd_id    = 2'($urandom);
    bus.cmd_index = 4'($urandom);
    bus.cmd_value = {$urandom, $urandom};
    if (!hold || !ok) bus.cmd_valid = 1'b0;
  endtask

  task automatic collect(
    input int mode, output string s, output int lat,
    output int errs, output bit to);
    int k;
    bit seen;
    bit stall;
    logic [7:0] held;
    s = "";
    lat = 0;
    errs = 0;
    to = 1'b0;
    seen = 1'b0;
    stall = 1'b0;
    held = 8'h00;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (k > 300) begin
        to = 1'b1;
        break;
      end
      case (mode)
        0: bus.tx_ready = 1'b1;
        1: bus.tx_ready = ((k % 3) == 1);
        default: bus.tx_ready = 1'($urandom);
      endcase
      if (stall && (bus.tx_valid !== 1'b1 ||
                    bus.tx_data !== held)) errs++;
      if (seen && bus.tx_valid !== 1'b1) errs++;
      if (bus.tx_valid === 1'b1 &&
          bus.cmd_ready !== 1'b0) errs++;
      if (bus.tx_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        lat = k;
      end
      stall = (bus.tx_valid === 1'b1) && !bus.tx_ready;
      held = bus.tx_data;
      if (bus.tx_valid === 1'b1 && bus.tx_ready) begin
        s = $sformatf("%s%c", s, bus.tx_data);
        if (bus.tx_data == 8'h0A) break;
      end
    end
    @(posedge clk);
  endtask

  task automatic run_frame(
    input logic [1:0] op, input logic [1:0] id,
    input logic [3:0] idx, input logic [63:0] v,
    input int mode, output string got,
    output int lat, output int errs);
    bit ok;
    bit to;
    send_cmd(op, id, idx, v, 1'b0, ok);
    collect(mode, got, lat, errs, to);
    if (!ok || to) errs += 1000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_tx: valid=%b data=%h want 0/00",
               bus.tx_valid, bus.tx_data);
    end
    n_tests++;
    if (bus.cmd_ready !== 1'b0 || busy !== 1'b0 ||
        frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b busy=%b cnt=%0d want 0/0/0",
               bus.cmd_ready, busy, frame_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%b before edge want 0",
               bus.cmd_ready);
    end
    @(negedge clk);
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b after edge want 1",
               bus.cmd_ready);
    end
  endtask

  task automatic test_binary();
    string got;
    string exp;
    int lat;
    int errs;
    run_frame(2'd0, 2'b01, 4'd3, 64'h05, 0, got, lat, errs);
    exp_cnt++;
    exp = model(2'd0, 2'b01, 4'd3, 64'h05);
    @(negedge clk);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL bin_frame: got '%s' want '%s'",
               vis(got), vis(exp));
    end
    n_tests++;
    if (lat != 1 || errs != 0) begin
      n_fail++;
      $display("FAIL bin_timing: lat=%0d errs=%0d want 1/0",
               lat, errs);
    end
    n_tests++;
    if (frame_cnt !== 16'(exp_cnt) || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bin_after: cnt=%0d ready=%b want %0d/1",
               frame_cnt, bus.cmd_ready, exp_cnt);
    end
  endtask

  task automatic test_float();
    logic [63:0] vals[3];
    string got;
    string exp;
    int lat;
    int errs;
    vals[0] = 64'd120;
    vals[1] = 64'd0;
    vals[2] = 64'hFFFF_0000_0000_FFFF;
    for (int i = 0; i < 3; i++) begin
      run_frame(2'd1, 2'b10, 4'd1, vals[i], 2, got, lat, errs);
      exp_cnt++;
      exp = model(2'd1, 2'b10, 4'd1, vals[i]);
      @(negedge clk);
      n_tests++;
      if (got != exp) begin
        n_fail++;
        $display("FAIL flt_frame%0d: got '%s' want '%s'",
                 i, vis(got), vis(exp));
      end
      n_tests++;
      if (lat != 17 || errs != 0) begin
        n_fail++;
        $display("FAIL flt_timing%0d: lat=%0d errs=%0d want 17/0",
                 i, lat, errs);
      end
      n_tests++;
      if (frame_cnt !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL flt_cnt%0d: cnt=%0d want %0d",
                 i, frame_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_tick_index();
    logic [1:0]  ops[3];
    logic [3:0]  idxs[3];
    logic [63:0] vs[3];
    string got;
    string exp;
    int lat;
    int errs;
    ops[0] = 2'd2; idxs[0] = 4'd0;  vs[0] = 64'd0;
    ops[1] = 2'd3; idxs[1] = 4'd0;  vs[1] = 64'd0;
    ops[2] = 2'd0; idxs[2] = 4'd12; vs[2] = 64'hFF;
    for (int i = 0; i < 3; i++) begin
      run_frame(ops[i], 2'b00, idxs[i], vs[i], 0, got, lat, errs);
      exp_cnt++;
      exp = model(ops[i], 2'b00, idxs[i], vs[i]);
      @(negedge clk);
      n_tests++;
      if (got != exp || lat != 1 || errs != 0) begin
        n_fail++;
        $display("FAIL short%0d: got '%s' lat=%0d errs=%0d want '%s' lat=1 errs=0",
                 i, vis(got), lat, errs, vis(exp));
      end
    end
  endtask

  task automatic test_back_to_back();
    string got;
    string exp;
    int lat;
    int errs;
    bit ok;
    bit to;
    send_cmd(2'd0, 2'b11, 4'd9, 64'hA5, 1'b1, ok);
    collect(1, got, lat, errs, to);
    exp_cnt++;
    exp = model(2'd0, 2'b11, 4'd9, 64'hA5);
    @(negedge clk);
    n_tests++;
    if (got != exp || !ok || to) begin
      n_fail++;
      $display("FAIL bp_frame: got '%s' want '%s'",
               vis(got), vis(exp));
    end
    n_tests++;
    if (errs != 0 || lat != 1) begin
      n_fail++;
      $display("FAIL bp_stall: errs=%0d lat=%0d want 0/1",
               errs, lat);
    end
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || frame_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL bp_idle: ready=%b cnt=%0d want 1/%0d",
               bus.cmd_ready, frame_cnt, exp_cnt);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    collect(0, got, lat, errs, to);
    exp_cnt++;
    @(negedge clk);
    n_tests++;
    if (got != "t\n" || lat != 1 || errs != 0 || to) begin
      n_fail++;
      $display("FAIL bp_second: got '%s' lat=%0d errs=%0d want 't<NL>' lat=1",
               vis(got), lat, errs);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [1:0]  id;
    logic [3:0]  idx;
    logic [63:0] v;
    string got;
    string exp;
    int lat;
    int errs;
    int want_lat;
    for (int i = 0; i < 30; i++) begin
      op  = 2'($urandom);
      id  = 2'($urandom);
      idx = 4'($urandom);
      v   = {$urandom, $urandom};
      if (i % 5 == 0) v[15:0] = 16'(i * 3);
      run_frame(op, id, idx, v, (i % 2) * 2, got, lat, errs);
      exp_cnt++;
      exp = model(op, id, idx, v);
      want_lat = (op == 2'd1) ? 17 : 1;
      @(negedge clk);
      n_tests++;
      if (got != exp || lat != want_lat || errs != 0) begin
        n_fail++;
        $display("FAIL rand%0d: got '%s' lat=%0d errs=%0d want '%s' lat=%0d",
                 i, vis(got), lat, errs, vis(exp), want_lat);
      end
      n_tests++;
      if (frame_cnt !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL rand_cnt%0d: cnt=%0d want %0d",
                 i, frame_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    string got;
    int lat;
    int errs;
    bit ok;
    bus.tx_ready = 1'b1;
    send_cmd(2'd0, 2'b01, 4'd7, 64'h3C, 1'b0, ok);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (!ok || bus.tx_valid !== 1'b1 || busy !== 1'b1 ||
        frame_cnt === 16'd0) begin
      n_fail++;
      $display("FAIL mid_pre: ok=%b valid=%b busy=%b cnt=%0d want 1/1/1/nonzero",
               ok, bus.tx_valid, busy, frame_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.tx_valid !== 1'b0 || frame_cnt !== 16'd0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b cnt=%0d busy=%b want 0/0/0",
               bus.tx_valid, frame_cnt, busy);
    end
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(2'd2, 2'b00, 4'd0, 64'd0, 0, got, lat, errs);
    exp_cnt++;
    @(negedge clk);
    n_tests++;
    if (got != "t\n" || errs != 0 || frame_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL mid_after: got '%s' errs=%0d cnt=%0d want 't<NL>' 0 %0d",
               vis(got), errs, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    int want;
    bit ok;
    want = 0;
    for (int f = 0; f < 5; f++) begin
      ok = 1'b0;
      @(negedge clk);
      bus2.cmd_op    = 2'd2;
      bus2.cmd_valid = 1'b1;
      bus2.tx_ready  = 1'b1;
      for (int i = 0; i < 50; i++) begin
        if (bus2.cmd_ready === 1'b1) break;
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus2.cmd_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus2.tx_valid === 1'b1 && bus2.tx_data === 8'h0A) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge clk);
      @(negedge clk);
      want = (want + 1) % 4;
      n_tests++;
      if (!ok || fc2 !== 2'(want)) begin
        n_fail++;
        $display("FAIL wrap%0d: cnt=%0d done=%b want %0d",
                 f, fc2, ok, want);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_id     = 2'd0;
    bus.cmd_index  = 4'd0;
    bus.cmd_value  = 64'd0;
    bus.tx_ready   = 1'b0;
    bus2.cmd_valid = 1'b0;
    bus2.cmd_op    = 2'd0;
    bus2.cmd_id    = 2'd0;
    bus2.cmd_index = 4'd0;
    bus2.cmd_value = 64'd0;
    bus2.tx_ready  = 1'b0;
    test_reset();
    test_binary();
    test_float();
    test_tick_index();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
